// File: rtl/pre_if_stage_pkg.sv
// Shared bus widths, field layouts and reset/exception addresses for the pre-IF stage.
package pre_if_stage_pkg;
  localparam int BR_BUS_WD        = 35;
  localparam int PFS_TO_FS_BUS_WD = 33;
  localparam int PFS_STALE        = 32;

  localparam logic [31:0] RESET_PC_DEF  = 32'hbfc00000;
  localparam logic [31:0] EX_VECTOR_DEF = 32'hbfc00380;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} pfs_state_t;

  typedef struct packed {
    logic        br_or_jump_op;
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
  } br_bus_t;

  typedef struct packed {
    logic        stale;
    logic [31:0] pc;
  } pfs_to_fs_bus_t;
endpackage

// File: rtl/pfs_redirect_buf.sv
// Priority merge of live redirects with a single-entry buffer of redirects not yet fetched.
module pfs_redirect_buf
  import pre_if_stage_pkg::*;
#(
  parameter logic [31:0] EX_VECTOR = EX_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_ex,
  input  logic        ws_eret,
  input  logic [31:0] cp0_epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        consume,
  output logic        redirect,
  output logic        pick_valid,
  output logic [31:0] pick_target,
  output logic        exc_pending
);
  logic        buf_valid;
  logic        buf_is_exc;
  logic [31:0] buf_target;
  logic        exc_now;
  logic [31:0] exc_target;

  assign exc_now     = ws_ex | ws_eret;
  assign exc_target  = ws_ex ? EX_VECTOR : cp0_epc;
  assign redirect    = exc_now | br_taken;
  assign exc_pending = buf_valid & buf_is_exc;
  assign pick_valid  = exc_now | buf_valid | br_taken;

  always_comb begin
    pick_target = br_target;
    if (exc_now)        pick_target = exc_target;
    else if (buf_valid) pick_target = buf_target;
  end

  // A pending exception/eret entry must survive any later branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid  <= 1'b0;
      buf_is_exc <= 1'b0;
      buf_target <= 32'h0;
    end else if (consume) begin
      buf_valid  <= 1'b0;
      buf_is_exc <= 1'b0;
    end else if (exc_now) begin
      buf_valid  <= 1'b1;
      buf_is_exc <= 1'b1;
      buf_target <= exc_target;
    end else if (br_taken && !exc_pending) begin
      buf_valid  <= 1'b1;
      buf_is_exc <= 1'b0;
      buf_target <= br_target;
    end
  end
endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: next-PC selection and address phase of the instruction SRAM port.
// Superseded in-flight fetches are handed to IF marked stale.
module pre_if_stage
  import pre_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] EX_VECTOR = EX_VECTOR_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fs_allowin,
  input  logic [BR_BUS_WD-1:0]        br_bus,
  input  logic                        ws_ex,
  input  logic                        ws_eret,
  input  logic [31:0]                 cp0_epc,
  output logic                        inst_sram_req,
  output logic                        inst_sram_wr,
  output logic [1:0]                  inst_sram_size,
  output logic [3:0]                  inst_sram_wstrb,
  output logic [31:0]                 inst_sram_addr,
  output logic [31:0]                 inst_sram_wdata,
  input  logic                        inst_sram_addr_ok,
  output logic                        pfs_to_fs_valid,
  output logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus
);
  br_bus_t        br;
  pfs_state_t     state, next_state;
  pfs_to_fs_bus_t out_bus;
  logic [31:0]    req_addr, last_pc, seq_base, next_pc, pick_target;
  logic           stale_flag, br_live, go, load, handoff_req, handoff_hold;
  logic           redirect, pick_valid, exc_pending, entry_stale;
  logic           unused_br_op;

  assign br           = br_bus;
  assign unused_br_op = br.br_or_jump_op;
  assign br_live      = br.br_taken & ~br.br_stall;

  // Exceptions, erets and a buffered exception entry all ignore br_stall.
  assign go           = (fs_allowin & ~br.br_stall) | ws_ex | ws_eret | exc_pending;
  assign handoff_req  = (state == REQ) & inst_sram_addr_ok & fs_allowin;
  assign handoff_hold = (state == HOLD) & fs_allowin;
  assign load         = ((state == IDLE) & go) | (handoff_req & go);
  assign entry_stale  = stale_flag | redirect;
  // In REQ the entry being handed over is the sequential predecessor; a stale
  // entry always has a redirect live or buffered, which overrides this base.
  assign seq_base     = (state == REQ) ? req_addr : last_pc;
  assign next_pc      = pick_valid ? pick_target : seq_base + 32'd4;

  pfs_redirect_buf #(.EX_VECTOR(EX_VECTOR)) u_redirect_buf (
    .clk        (clk),
    .reset      (reset),
    .ws_ex      (ws_ex),
    .ws_eret    (ws_eret),
    .cp0_epc    (cp0_epc),
    .br_taken   (br_live),
    .br_target  (br.br_target),
    .consume    (load),
    .redirect   (redirect),
    .pick_valid (pick_valid),
    .pick_target(pick_target),
    .exc_pending(exc_pending)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (go) next_state = REQ;
      REQ:  if (inst_sram_addr_ok) next_state = !fs_allowin ? HOLD : (go ? REQ : IDLE);
      HOLD: if (fs_allowin) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    inst_sram_req   = (state == REQ);
    pfs_to_fs_valid = handoff_req | handoff_hold;
    out_bus.stale   = entry_stale;
    out_bus.pc      = req_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr   <= 32'h0;
      last_pc    <= RESET_PC - 32'd4;
      stale_flag <= 1'b0;
    end else begin
      if (load) begin
        req_addr   <= next_pc;
        stale_flag <= 1'b0;
      end else if (state != IDLE && redirect) begin
        stale_flag <= 1'b1;
      end
      if ((handoff_req || handoff_hold) && !entry_stale) last_pc <= req_addr;
    end
  end

  assign pfs_to_fs_bus   = out_bus;
  assign inst_sram_addr  = req_addr;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
endmodule

// File: tb/tb_pre_if_stage.sv
// Directed cycle table for the fetch/redirect corner cases, then random traffic
// checked against an architectural PC-stream model.
module tb_pre_if_stage;
  import pre_if_stage_pkg::*;

  localparam logic [31:0] RPC = 32'hbfc00000;
  localparam logic [31:0] EXV = 32'hbfc00380;

  logic        clk, reset, fs_allowin, ws_ex, ws_eret, addr_ok;
  logic [34:0] br_bus;
  logic [31:0] cp0_epc, addr, wdata;
  logic        req, wr, pv;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [32:0] bus;

  int tests = 0;
  int fails = 0;

  pre_if_stage dut (
    .clk(clk), .reset(reset), .fs_allowin(fs_allowin), .br_bus(br_bus),
    .ws_ex(ws_ex), .ws_eret(ws_eret), .cp0_epc(cp0_epc),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
    .inst_sram_wstrb(wstrb), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .inst_sram_addr_ok(addr_ok), .pfs_to_fs_valid(pv), .pfs_to_fs_bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic rst, fa, aok, stall, brt;
    logic [31:0] brtgt;
    logic ex, eret;
    logic [31:0] epc;
    logic e_req;
    logic [31:0] e_addr;
    logic e_pv, e_stale;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, fa, aok, stall, brt, input logic [31:0] brtgt,
                              input logic ex, eret, input logic [31:0] epc,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_pv, e_stale, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.fa = fa; v.aok = aok; v.stall = stall; v.brt = brt; v.brtgt = brtgt;
    v.ex = ex; v.eret = eret; v.epc = epc; v.e_req = e_req; v.e_addr = e_addr;
    v.e_pv = e_pv; v.e_stale = e_stale; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, fa, aok, stall, brt, input logic [31:0] brtgt,
                       input logic ex, eret, input logic [31:0] epc);
    reset = rst; fs_allowin = fa; addr_ok = aok;
    br_bus = {brt, stall, brt, brtgt};
    ws_ex = ex; ws_eret = eret; cp0_epc = epc;
  endtask

  logic [31:0] exp_next, wait_addr, tgt;
  int redir_since, stale_seen, good, cool;
  bit waiting, held, ex_r, eret_r;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // reset row, sequential, delayed addr_ok, branch in flight
    vecs.push_back(mk(1,1,1,0,0,0,0,0,0,                      0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0,                      0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0,                      1,RPC,1,0,RPC));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,                      1,RPC+4,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,                      1,RPC+4,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,                      1,RPC+4,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0,                      1,RPC+4,1,0,RPC+4));
    vecs.push_back(mk(0,1,1,0,1,32'h80001000,0,0,0,           1,RPC+8,1,1,RPC+8));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0,                      1,32'h80001000,1,0,32'h80001000));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0,                      1,32'h80001004,1,0,32'h80001004));
    // HOLD, exception under br_stall
    vecs.push_back(mk(0,0,1,0,0,0,0,0,0,                      1,32'h80001008,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,1,0,0,                      0,0,0,0,0));
    vecs.push_back(mk(0,1,0,1,0,0,0,0,0,                      0,0,1,1,32'h80001008));
    vecs.push_back(mk(0,1,0,1,0,0,0,0,0,                      0,0,0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,0,0,0,                      1,EXV,1,0,EXV));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0,                      0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,                      1,EXV+4,0,0,0));
    // eret with same-cycle branch, later branch must not displace it
    vecs.push_back(mk(0,1,0,0,1,32'h80003000,0,1,32'h80002000,1,EXV+4,0,0,0));
    vecs.push_back(mk(0,1,0,0,1,32'h80004000,0,0,0,           1,EXV+4,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0,                      1,EXV+4,1,1,EXV+4));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0,                      1,32'h80002000,1,0,32'h80002000));
    // HOLD without redirect: no new request until IF takes it
    vecs.push_back(mk(0,0,1,0,0,0,0,0,0,                      1,32'h80002004,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,0,0,                      0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,                      0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,                      0,0,1,0,32'h80002004));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0,                      0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0,                      1,32'h80002008,1,0,32'h80002008));
    // ws_ex and ws_eret together: exception wins
    vecs.push_back(mk(0,1,0,0,0,0,1,1,32'h80002000,           1,32'h8000200c,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0,                      1,32'h8000200c,1,1,32'h8000200c));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0,                      1,EXV,1,0,EXV));
    // reset while a request is outstanding
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,                      1,EXV+4,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,0,                      1,EXV+4,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0,                      0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0,                      1,RPC,1,0,RPC));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].fa, vecs[i].aok, vecs[i].stall, vecs[i].brt,
            vecs[i].brtgt, vecs[i].ex, vecs[i].eret, vecs[i].epc);
      #1;
      chk($sformatf("v%0d_req", i), {31'h0, req}, {31'h0, vecs[i].e_req});
      if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), addr, vecs[i].e_addr);
      chk($sformatf("v%0d_pfs_valid", i), {31'h0, pv}, {31'h0, vecs[i].e_pv});
      if (vecs[i].e_pv) begin
        chk($sformatf("v%0d_stale", i), {31'h0, bus[32]}, {31'h0, vecs[i].e_stale});
        chk($sformatf("v%0d_pc", i), bus[31:0], vecs[i].e_pc);
      end
      if (i == 0) begin
        chk("reset_const_size", {30'h0, size}, 32'h2);
        chk("reset_const_wr_wstrb_wdata", {wdata[27:0], wstrb} | {31'h0, wr}, 32'h0);
      end
    end

    // Random traffic: non-stale handoffs must form the architectural PC stream.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_next = RPC; redir_since = 0; stale_seen = 0; good = 0; cool = 0;
    waiting = 0; held = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      ex_r = 0; eret_r = 0; tgt = 32'h0;
      if (cool > 0) cool--;
      else if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 1) == 1) ex_r = 1;
        else begin eret_r = 1; tgt = $urandom & 32'hfffffffc; end
        cool = 12;
      end
      drive(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) == 0, 0, 0, ex_r, eret_r, tgt);
      #1;
      if (waiting) begin
        chk("rnd_req_held", {31'h0, req}, 32'h1);
        chk("rnd_addr_stable", addr, wait_addr);
      end
      if (held) chk("rnd_no_req_in_hold", {31'h0, req}, 32'h0);
      if (!fs_allowin) chk("rnd_pv_without_allowin", {31'h0, pv}, 32'h0);
      if (ex_r || eret_r) begin
        redir_since++;
        exp_next = ex_r ? EXV : tgt;
      end
      if (pv) begin
        if (ex_r || eret_r) begin
          chk("rnd_stale_on_redirect", {31'h0, bus[32]}, 32'h1);
          stale_seen++;
        end else if (bus[32]) begin
          stale_seen++;
          chk("rnd_stale_budget", {31'h0, stale_seen <= redir_since}, 32'h1);
        end else begin
          chk("rnd_pc_stream", bus[31:0], exp_next);
          exp_next = bus[31:0] + 32'd4;
          redir_since = 0; stale_seen = 0; good++;
        end
        held = 0;
      end
      waiting = req && !addr_ok;
      wait_addr = addr;
      if (req && addr_ok && !fs_allowin) held = 1;
    end
    chk("rnd_progress", {31'h0, good > 200}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
